// File: rtl/alu_pkg.sv
// alu_pkg: shared op and FSM state encodings for alu_seq and alu_core.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

  // Logic ops (m=0, l=1)
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOT  = 2'b11;

  // Arithmetic ops (m=0, l=0)
  localparam logic [1:0] OP_NEGA = 2'b00;
  localparam logic [1:0] OP_NEGB = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  // Multi-cycle ops (m=1); op=1x is reserved
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;

  // Sequencer states
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RUN     = 1'b1;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit logic/arithmetic unit with Z/C/S/V flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             l,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             c,
  output logic             s,
  output logic             v
);

  localparam logic [WIDTH:0]   ONE     = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

  logic [WIDTH:0] sum;

  // Select the logic or (WIDTH+1)-bit arithmetic result and its carry/overflow
  always_comb begin
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    if (l) begin
      case (op)
        OP_AND:  r = a & b;
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        default: r = ~a;
      endcase
    end else begin
      case (op)
        OP_NEGA: begin
          sum = {1'b0, ~a} + ONE;
          // Two's-complement negation only overflows on the most negative value
          v   = (a == MIN_NEG);
        end
        OP_NEGB: begin
          sum = {1'b0, ~b} + ONE;
          v   = (b == MIN_NEG);
        end
        OP_ADD: begin
          sum = {1'b0, a} + {1'b0, b};
          v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        default: begin
          sum = {1'b0, a} + {1'b0, ~b} + ONE;
          v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
      endcase
      r = sum[WIDTH-1:0];
      c = sum[WIDTH];
    end
  end

  assign s = r[WIDTH-1];
  assign z = ~|r;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU plus multi-cycle unsigned shift-add MUL and restoring DIV.
// Latency: 1 cycle after accept for ALU ops, DIV-by-0 and reserved ops; WIDTH+1 for MUL/DIV.
// Backpressure: start ignored while busy (no queueing); a start during the done cycle is accepted.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             m,
  input  logic             l,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             z,
  output logic             c,
  output logic             s,
  output logic             v,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  logic [0:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic             pend_q;   // a one-cycle op was accepted last edge and completes now
  logic             m_q, l_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] work_hi, work_lo;   // MUL: {product hi, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   mul_acc, div_shf, div_dif;
  logic [WIDTH-1:0] core_r;
  logic             core_z, core_c, core_s, core_v;
  logic             accept, go_run, fin_run;

  assign busy    = (state_q == RUN);
  assign accept  = start && !busy;
  // DIV by zero skips iteration and completes like a single-cycle op
  assign go_run  = m && !op[1] && ((op == OP_MUL) || (b != '0));
  assign fin_run = (state_q == RUN) && (cnt_q == '0);

  alu_core #(.WIDTH(WIDTH)) u_core (
    .l  (l_q),
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .r  (core_r),
    .z  (core_z),
    .c  (core_c),
    .s  (core_s),
    .v  (core_v)
  );

  // One shift-add (MUL) or restoring-subtract (DIV) step on the working registers
  always_comb begin
    mul_acc = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_q} : '0);
    div_shf = {work_hi, work_lo[WIDTH-1]};
    div_dif = div_shf - {1'b0, b_q};
    if (op_q == OP_MUL) begin
      hi_nxt = mul_acc[WIDTH:1];
      lo_nxt = {mul_acc[0], work_lo[WIDTH-1:1]};
    end else if (!div_dif[WIDTH]) begin
      hi_nxt = div_dif[WIDTH-1:0];
      lo_nxt = {work_lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt = div_shf[WIDTH-1:0];
      lo_nxt = {work_lo[WIDTH-2:0], 1'b0};
    end
  end

  // Accept requests, latch operands and sequence the MUL/DIV iterations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      m_q     <= 1'b0;
      l_q     <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_hi <= '0;
      work_lo <= '0;
    end else begin
      pend_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          m_q  <= m;
          l_q  <= l;
          op_q <= op;
          a_q  <= a;
          b_q  <= b;
          if (go_run) begin
            state_q <= RUN;
            cnt_q   <= CW'(WIDTH);
            work_hi <= '0;
            work_lo <= a;
          end else begin
            pend_q <= 1'b1;
          end
        end
      end else if (cnt_q == '0) begin
        state_q <= IDLE;
      end else begin
        cnt_q   <= cnt_q - CW'(1);
        work_hi <= hi_nxt;
        work_lo <= lo_nxt;
      end
    end
  end

  // Result/flag register: updated only on completion, done/err pulse for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r    <= '0;
      r_hi <= '0;
      z    <= 1'b1;
      c    <= 1'b0;
      s    <= 1'b0;
      v    <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (pend_q) begin
        done <= 1'b1;
        if (!m_q) begin
          r    <= core_r;
          r_hi <= '0;
          z    <= core_z;
          c    <= core_c;
          s    <= core_s;
          v    <= core_v;
        end else if (op_q == OP_DIV) begin
          r    <= '1;
          r_hi <= a_q;
          z    <= 1'b0;
          c    <= 1'b0;
          s    <= 1'b0;
          v    <= 1'b0;
          err  <= 1'b1;
        end else begin
          // Reserved op: results and flags keep their previous values
          err  <= 1'b1;
        end
      end else if (fin_run) begin
        done <= 1'b1;
        r    <= work_lo;
        r_hi <= work_hi;
        s    <= 1'b0;
        v    <= 1'b0;
        if (op_q == OP_MUL) begin
          z <= ~|{work_hi, work_lo};
          c <= |work_hi;
        end else begin
          z <= ~|work_lo;
          c <= 1'b0;
        end
      end
    end
  end

endmodule
